// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for the four-way arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  // Scans from last_owner+1 upward with wrap, so last_owner itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last_owner);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = last_owner;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_owner + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/mux41_n.sv
// Plain 4:1 data multiplexer, DLEN bits wide, selected by a binary index.
module mux41_n #(
  parameter int DLEN = 32
) (
  input  logic [DLEN-1:0] din00,
  input  logic [DLEN-1:0] din01,
  input  logic [DLEN-1:0] din10,
  input  logic [DLEN-1:0] din11,
  input  logic [1:0]      sel,
  output logic [DLEN-1:0] dout
);
  always_comb begin
    dout = din00;
    case (sel)
      2'b00:   dout = din00;
      2'b01:   dout = din01;
      2'b10:   dout = din10;
      2'b11:   dout = din11;
      default: dout = din00;
    endcase
  end
endmodule

// File: rtl/arb4_rr_ctrl.sv
// Round-robin owner arbiter for a shared 4:1 data path.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module arb4_rr_ctrl
  import arb_pkg::*;
#(
  parameter int DLEN     = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   done,
  input  logic [DLEN-1:0]      din00,
  input  logic [DLEN-1:0]      din01,
  input  logic [DLEN-1:0]      din10,
  input  logic [DLEN-1:0]      din11,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  output logic [DLEN-1:0]      dout,
  output logic                 dout_vld,
  output logic                 timeout
);
  // Handshake: a requester holds req high for its whole transaction; the owner
  // ends it by pulsing done on its last granted cycle or by dropping req.
  // dout is only meaningful while dout_vld is high.

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d, last_q, last_d, winner;
  logic               release_nat, release_any, force_rel;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;
  logic              new_grant;
`else
  localparam bit unused_hold_max = (HOLD_MAX >= 2);
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    force_rel   = 1'b0;
    release_nat = (state_q == GRANT) && (done[sel_q] || !req[sel_q]);
`ifdef ARB_TIMEOUT_EN
    force_rel   = (state_q == GRANT) && !release_nat && (hold_q == HOLD_W'(HOLD_MAX - 1));
`endif
    release_any = release_nat || force_rel;
    // On release the outgoing owner becomes the lowest-priority candidate.
    winner      = rr_pick(req, (state_q == GRANT) ? sel_q : last_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = NUM_REQ'(1) << winner;
        end
      end
      GRANT: begin
        if (release_any) begin
          last_d = sel_q;
          if (|req) begin
            sel_d = winner;
            gnt_d = NUM_REQ'(1) << winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign new_grant = (state_d == GRANT) && ((state_q == IDLE) || release_any);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (new_grant)
        hold_q <= '0;
      else if (state_q == GRANT)
        hold_q <= hold_q + HOLD_W'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = (state_q == GRANT);
  assign dout_vld = busy;

  mux41_n #(.DLEN(DLEN)) u_mux (
    .din00 (din00),
    .din01 (din01),
    .din10 (din10),
    .din11 (din11),
    .sel   (sel_q),
    .dout  (dout)
  );
endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench for arb4_rr_ctrl: directed scenarios plus randomized traffic
// against a behavioural model. Build with ARB_TIMEOUT_EN to cover forced release.
module tb_arb4_rr_ctrl;
  localparam int DLEN = 32;
  localparam int HM   = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk, rst;
  logic [3:0]      req, done;
  logic [DLEN-1:0] dins [4];
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic            busy, dout_vld, timeout;
  logic [DLEN-1:0] dout;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  // model state
  bit m_busy;
  int m_sel, m_last, m_hold;
  bit m_to;

  arb4_rr_ctrl #(.DLEN(DLEN), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .din00(dins[0]), .din01(dins[1]), .din10(dins[2]), .din11(dins[3]),
    .gnt(gnt), .sel(sel), .busy(busy), .dout(dout), .dout_vld(dout_vld),
    .timeout(timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = '0;
    tick();
    rst = 1'b0;
  endtask

  // behavioural reference: owner index and priority pointer as plain integers
  function automatic int m_pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic model_step(input bit r_v, input logic [3:0] q, input logic [3:0] d);
    bit rel, frc;
    if (r_v) begin
      m_busy = 0; m_sel = 0; m_last = 3; m_hold = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      if (q != 0) begin m_busy = 1; m_sel = m_pick(q, m_last); m_hold = 0; end
    end else begin
      rel = d[m_sel] || !q[m_sel];
      frc = TO_EN && !rel && (m_hold == HM - 1);
      if (rel || frc) begin
        m_last = m_sel;
        m_to   = frc;
        if (q != 0) begin m_sel = m_pick(q, m_last); m_hold = 0; end
        else m_busy = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 4'b1111;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b want 00", sel); end
    n_cmp++; if (busy !== 1'b0 || dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, dout_vld); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst = 1'b0; req = '0; done = '0;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
    do_reset();
    req = 4'b1111;
    tick();
    n_cmp++; if (gnt !== exp_g[0] || sel !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL rot_first: gnt %b sel %0d busy %b want 0001 0 1", gnt, sel, busy); end
    for (int i = 0; i < 3; i++) begin
      done = 4'(1 << i);
      tick();
      n_cmp++; if (gnt !== exp_g[i+1] || sel !== 2'(i + 1) || busy !== 1'b1) begin n_fail++; $display("FAIL rot_step%0d: gnt %b sel %0d busy %b want %b %0d 1", i, gnt, sel, busy, exp_g[i+1], i + 1); end
    end
    done = '0;
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rot_hold: got %b want 1000", gnt); end
    req = '0;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd3) begin n_fail++; $display("FAIL rot_idle: gnt %b busy %b sel %0d want 0000 0 3", gnt, busy, sel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 2; i++) begin
      done = 4'b0100;
      tick();
      n_cmp++; if (gnt !== 4'b0100 || busy !== 1'b1 || sel !== 2'd2) begin n_fail++; $display("FAIL b2b_done%0d: gnt %b busy %b sel %0d want 0100 1 2", i, gnt, busy, sel); end
      done = '0;
      tick();
      n_cmp++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap%0d: gnt %b busy %b want 0100 1", i, gnt, busy); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_foreign_done();
    do_reset();
    req = 4'b0010;
    tick();
    done = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0010 || busy !== 1'b1) begin n_fail++; $display("FAIL foreign_done%0d: gnt %b busy %b want 0010 1", i, gnt, busy); end
    end
    done = '0; req = '0;
    tick();
    n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd1) begin n_fail++; $display("FAIL drop_req: busy %b gnt %b sel %0d want 0 0000 1", busy, gnt, sel); end
    done = 4'b0010;
    tick();
    n_cmp++; if (busy !== 1'b0 || sel !== 2'd1) begin n_fail++; $display("FAIL idle_done: busy %b sel %0d want 0 1", busy, sel); end
    done = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    tick();
    n_cmp++; if (gnt !== 4'b1000 || sel !== 2'd3) begin n_fail++; $display("FAIL mid_pre: gnt %b sel %0d want 1000 3", gnt, sel); end
    rst = 1'b1; done = 4'b1000;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin n_fail++; $display("FAIL mid_rst: gnt %b busy %b sel %0d want 0000 0 0", gnt, busy, sel); end
    rst = 1'b0; done = '0; req = 4'b1001;
    tick();
    n_cmp++; if (gnt !== 4'b0001 || sel !== 2'd0) begin n_fail++; $display("FAIL mid_after: gnt %b sel %0d want 0001 0", gnt, sel); end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    tick();
    if (TO_EN) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        n_cmp++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_hold%0d: gnt %b timeout %b want 0001 0", i, gnt, timeout); end
      end
      tick();
      n_cmp++; if (gnt !== 4'b0010 || timeout !== 1'b1) begin n_fail++; $display("FAIL to_fire: gnt %b timeout %b want 0010 1", gnt, timeout); end
      tick();
      n_cmp++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse: gnt %b timeout %b want 0010 0", gnt, timeout); end
    end else begin
      for (int i = 0; i < 100; i++) begin
        tick();
        n_cmp++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin n_fail++; $display("FAIL no_to%0d: gnt %b timeout %b want 0001 0", i, gnt, timeout); end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_data();
    for (int i = 0; i < 4; i++) dins[i] = DLEN'(32'hA0 + i);
    for (int i = 0; i < 4; i++) begin
      do_reset();
      req = 4'(1 << i);
      tick();
      n_cmp++; if (dout !== DLEN'(32'hA0 + i) || dout_vld !== 1'b1) begin n_fail++; $display("FAIL data_own%0d: dout %h vld %b want %h 1", i, dout, dout_vld, 32'hA0 + i); end
    end
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    n_cmp++; if (dout !== DLEN'(32'hA2) || dout_vld !== 1'b0) begin n_fail++; $display("FAIL data_idle: dout %h vld %b want a2 0", dout, dout_vld); end
  endtask

  task automatic test_random();
    logic [3:0] exp_g, got_g;
    bit         r_v;
    for (int i = 0; i < 4; i++) dins[i] = DLEN'($urandom);
    rst = 1'b1; req = '0; done = '0;
    model_step(1'b1, req, done);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r_v = ($urandom_range(0, 63) == 0);
      rst = r_v;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      model_step(r_v, req, done);
      exp_q.push_back(m_busy ? 4'(1 << m_sel) : 4'b0000);
      tick();
      exp_g = exp_q.pop_front();
      got_g = gnt;
      n_cmp++; if (got_g !== exp_g) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, got_g, exp_g); end
      n_cmp++; if (sel !== 2'(m_sel) || busy !== m_busy || dout_vld !== m_busy) begin n_fail++; $display("FAIL rnd_state c%0d: sel %0d busy %b vld %b want %0d %b", c, sel, busy, dout_vld, m_sel, m_busy); end
      n_cmp++; if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, timeout, m_to); end
      n_cmp++; if (dout !== dins[m_sel]) begin n_fail++; $display("FAIL rnd_dout c%0d: got %h want %h", c, dout, dins[m_sel]); end
    end
    rst = 1'b0; req = '0; done = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; done = '0;
    for (int i = 0; i < 4; i++) dins[i] = '0;
    repeat (2) tick();
    test_reset();
    test_rotation();
    test_back_to_back();
    test_foreign_done();
    test_reset_mid_grant();
    test_timeout();
    test_data();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/arb4_rr_ctrl.md
Name: arb4_rr_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data path between four requesters.
- Grants exclusive ownership to one requester at a time and drives the 2-bit mux select and one-hot grant.
- Presents the winner's data on dout.
- Sits in front of a shared resource (memory/bus port) in the RISC-V core.

Parameters:
- DLEN, 32, data width of each requester input and of dout.
- HOLD_MAX, 16, maximum grant length in cycles before forced release; used only when ARB_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per requester; bit i = requester i.
- done  input  4  end-of-transaction flag per requester; only the owner's bit is honoured.
- din00  input  DLEN  data from requester 0.
- din01  input  DLEN  data from requester 1.
- din10  input  DLEN  data from requester 2.
- din11  input  DLEN  data from requester 3.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  binary index of current or last owner, registered; feeds the mux.
- busy  output  1  high while in GRANT state.
- dout  output  DLEN  combinational mux of din by sel.
- dout_vld  output  1  equals busy.
- timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Interface rule: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- States:
  - IDLE: no owner.
  - GRANT: one owner, index held in sel.
- Reset (rst sampled high at an edge):
  - state = IDLE, gnt = 0, sel = 2'b00, busy = 0, timeout = 0, hold counter = 0.
  - Last-owner pointer = 3, so requester 0 has top priority after reset.
- Priority: rotate starting at (last_owner+1) mod 4 and wrap; last_owner is lowest.
- IDLE:
  - If req != 0 at edge N, then at N+1: state = GRANT, gnt = onehot(winner), sel = winner, busy = 1.
  - Grant latency is exactly 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT holds while req[sel] = 1 and done[sel] = 0.
- Release condition: done[sel] = 1 or req[sel] = 0 at edge N. The cycle with done high is the owner's last granted cycle.
- On release at edge N:
  - last_owner = sel.
  - If any req bit is high (the owner's bit counts, at lowest priority), re-grant the new winner at N+1 with no idle bubble; state stays GRANT.
  - Otherwise at N+1: state = IDLE, gnt = 0, busy = 0.
- Sole persistent requester asserting done is re-granted back-to-back.
- done from non-owners is ignored at all times; done while IDLE is ignored.
- done and req drop on the same cycle count as a single release.
- sel retains the last owner while IDLE, which keeps dout stable; dout is not qualified, so consumers use dout_vld.
- gnt is always zero or one-hot; gnt == onehot(sel) whenever busy = 1.
- Reset mid-grant: gnt and busy are 0 on the edge after rst is sampled; a pending done is discarded.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter clears on every new grant, including back-to-back re-grants, and increments each GRANT cycle.
  - If the counter reaches HOLD_MAX-1 with no release, force a release at that edge using normal release rules.
  - timeout pulses 1 for exactly the next cycle.
  - Max grant length is HOLD_MAX cycles.
  - A natural release on the same edge takes precedence, and timeout stays 0.
- Undefined: no counter; timeout is constant 0; grants last indefinitely.

Decomposition:
- Package arb_pkg:
  - constants NUM_REQ = 4 and SEL_W = 2.
  - state typedef {IDLE, GRANT}.
  - function rr_pick(req, last_owner) returning a 2-bit winner index.
- One sub-module: an instance of the existing 4:1 mux module (mux41_n, DLEN passed through) produces dout from din00..din11 and sel.

Test Plan:
1. Reset then req = 4'b1111 → gnt = 0001 next cycle, sel = 00. Pulse done[0] → gnt = 0010 on the following cycle, no idle bubble. Then done[1] gives 0100, then done[2] gives 1000.
2. Only req[2] held, done[2] pulsed twice → gnt = 0100 throughout; busy never drops; sel = 10.
3. Owner 1 granted and done[3] = 1 while req[3] = 0 → ignored; gnt stays 0010. Then req[1] drops → busy = 0 next cycle, sel stays 01.
4. Owner 3 granted and rst = 1 for one cycle → gnt = 0000, busy = 0, sel = 00 next cycle. Then req = 1001 → requester 0 wins.
5. ARB_TIMEOUT_EN with HOLD_MAX = 4, req = 0011, no done → gnt = 0001 for 4 cycles, then timeout pulse with gnt = 0010. Without the macro, gnt stays 0001 for 100 cycles and timeout stays 0.
6. din00..din11 = 0xA0..0xA3, owner 2 granted → dout = 0xA2 with dout_vld = 1. After release with no requests → dout stays 0xA2 with dout_vld = 0.
